// File: rtl/bcd_display_formatter.sv
// Binary-to-BCD formatter feeding an 8-digit LED driver: double dabble, one bit per clock.
// Outputs only change on completion, so the driver never sees a half-converted value.
//
// state    | meaning
// ---------|-----------------------------------------------------------
// ST_IDLE  | waiting for start; data/dps/ovf hold the last result
// ST_SHIFT | one add-3 + shift iteration per clock, 32 iterations
// ST_LOAD  | publish BCD (or error pattern) and pulse done
module bcd_display_formatter #(
    parameter logic [31:0] ERR_PATTERN = 32'hEEEE_EEEE
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] value,
    input  logic        dp_en,
    input  logic [2:0]  dp_pos,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        ovf,
    output logic [31:0] data,
    output logic [7:0]  dps
);

    localparam logic [31:0] MAX_VALUE = 32'd99_999_999;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_bin;
    logic [31:0] r_bcd;
    logic [4:0]  r_cnt;
    logic        r_ovf_pend;
    logic        r_dp_en;
    logic [2:0]  r_dp_pos;
    logic        r_done;
    logic        r_ovf;
    logic [31:0] r_data;
    logic [7:0]  r_dps;
    logic [31:0] w_bcd_adj;
    logic        w_too_big;
    logic        w_last;

    assign w_too_big = (value > MAX_VALUE);
    assign w_last    = (r_cnt == 5'd31);

    // Per-nibble correction is a plain 4-bit add; no carry crosses digits.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < 8; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5)
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next = w_too_big ? ST_LOAD : ST_SHIFT;
            ST_SHIFT: if (w_last) w_next = ST_LOAD;
            ST_LOAD:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_bin      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_dp_en    <= 1'b0;
            r_dp_pos   <= '0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
            r_data     <= '0;
            r_dps      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_bin      <= value;
                        r_bcd      <= '0;
                        r_cnt      <= '0;
                        r_ovf_pend <= w_too_big;
                        r_dp_en    <= dp_en;
                        r_dp_pos   <= dp_pos;
                    end
                end
                ST_SHIFT: begin
                    r_bcd <= {w_bcd_adj[30:0], r_bin[31]};
                    r_bin <= {r_bin[30:0], 1'b0};
                    r_cnt <= r_cnt + 5'd1;
                end
                ST_LOAD: begin
                    r_done <= 1'b1;
                    if (r_ovf_pend) begin
                        r_data <= ERR_PATTERN;
                        r_dps  <= 8'hFF;
                        r_ovf  <= 1'b1;
                    end else begin
                        r_data <= r_bcd;
                        r_dps  <= r_dp_en ? (8'h01 << r_dp_pos) : 8'h00;
                        r_ovf  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = r_done;
    assign ovf  = r_ovf;
    assign data = r_data;
    assign dps  = r_dps;

endmodule

// File: tb/tb_bcd_display_formatter.sv
// Scoreboard bench for bcd_display_formatter: a decimal reference model queues
// expected results and latencies; a negedge monitor checks every done pulse.
`timescale 1ns/1ps
module tb_bcd_display_formatter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] value = '0;
    logic        dp_en = 1'b0;
    logic [2:0]  dp_pos = '0;
    logic        start = 1'b0;
    logic        busy, done, ovf;
    logic [31:0] data;
    logic [7:0]  dps;

    bcd_display_formatter dut (
        .clk(clk), .resetn(resetn), .value(value), .dp_en(dp_en),
        .dp_pos(dp_pos), .start(start), .busy(busy), .done(done),
        .ovf(ovf), .data(data), .dps(dps)
    );

    always #7.5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  dps;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference model: decimal digits by division, independent of the shift algorithm.
    function automatic exp_t model(input logic [31:0] v, input logic en,
                                   input logic [2:0] pos, input int edge_e);
        exp_t e;
        longint t;
        e.data = '0;
        if (v > 32'd99_999_999) begin
            e.data = 32'hEEEE_EEEE;
            e.dps  = 8'hFF;
            e.ovf  = 1'b1;
            e.cyc  = edge_e + 1;
        end else begin
            t = v;
            for (int k = 0; k < 8; k++) begin
                e.data[4*k +: 4] = 4'(t % 10);
                t = t / 10;
            end
            e.dps = 8'h00;
            if (en) e.dps[pos] = 1'b1;
            e.ovf = 1'b0;
            e.cyc = edge_e + 33;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (resetn && done) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pending request (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("data", data, e.data);
                chk("dps", 32'(dps), 32'(e.dps));
                chk("ovf", 32'(ovf), 32'(e.ovf));
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
                chk("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    // Called on a negedge while the DUT is idle; the next posedge is edge E.
    task automatic go(input logic [31:0] v, input logic en, input logic [2:0] pos);
        value  = v;
        dp_en  = en;
        dp_pos = pos;
        start  = 1'b1;
        q.push_back(model(v, en, pos, cyc + 1));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_q();
        int n = 0;
        while (q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: got %0d pending results expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        logic [31:0] v;
        repeat (2) @(negedge clk);
        chk("rst_data", data, 32'h0);
        chk("rst_dps", 32'(dps), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        resetn = 1'b1;
        @(negedge clk);

        go(32'd12_345_678, 1'b1, 3'd2); wait_q();
        chk("busy_idle", 32'(busy), 32'h0);
        go(32'd0, 1'b0, 3'd0);          wait_q();
        go(32'd99_999_999, 1'b0, 3'd5); wait_q();
        go(32'd100_000_000, 1'b1, 3'd3); wait_q();
        go(32'd7, 1'b0, 3'd0);          wait_q();
        chk("hold_data", data, 32'h0000_0007);

        // start during a conversion is ignored and input changes do not disturb it
        go(32'd55_501_234, 1'b1, 3'd6);
        repeat (4) @(negedge clk);
        value = 32'd11; dp_en = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_q();
        repeat (40) @(negedge clk);

        // reset mid-conversion abandons the request
        go(32'd87_654_321, 1'b1, 3'd7);
        repeat (14) @(negedge clk);
        resetn = 1'b0;
        #1;
        q.delete();
        chk("mid_rst_data", data, 32'h0);
        chk("mid_rst_dps", 32'(dps), 32'h0);
        chk("mid_rst_ovf", 32'(ovf), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_done", 32'(done), 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        go(32'd42, 1'b0, 3'd0); wait_q();

        // back-to-back sweep with start held high
        start = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            int n;
            if (($urandom & 32'hF) == 0)
                v = $urandom_range(32'hFFFF_FFFF, 32'd100_000_000);
            else
                v = $urandom_range(32'd99_999_999, 0);
            value  = v;
            dp_en  = 1'($urandom);
            dp_pos = 3'($urandom);
            q.push_back(model(v, dp_en, dp_pos, cyc + 1));
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!done && n < 40);
            if (!done) begin
                n_tests++;
                n_fail++;
                $display("FAIL sweep_timeout: got no done expected done within 34 cycles (iter %0d)", i);
                q.delete();
                break;
            end
        end
        start = 1'b0;
        wait_q();
        repeat (40) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
